// File: rtl/trdb_branch_pkt_emitter.sv
// Snapshots the branch map into a format-1 (branch) packet payload when the map fills or an
// address-bearing packet is requested, flushes the map in the same cycle, and hands it on.
module trdb_branch_pkt_emitter #(
    parameter int BRANCH_MAP_LEN   = 31,
    parameter int BRANCH_COUNT_LEN = 5,
    parameter int XLEN             = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [BRANCH_MAP_LEN-1:0]   map_i,
    input  logic [BRANCH_COUNT_LEN-1:0] branches_i,
    input  logic                        is_full_i,
    input  logic                        addr_req_i,
    input  logic [XLEN-1:0]             addr_i,
    input  logic                        pkt_ready_i,
    output logic                        flush_o,
    output logic                        pkt_valid_o,
    output logic [1:0]                  pkt_format_o,
    output logic [BRANCH_COUNT_LEN-1:0] pkt_branches_o,
    output logic [BRANCH_MAP_LEN-1:0]   pkt_map_o,
    output logic                        pkt_has_addr_o,
    output logic [XLEN-1:0]             pkt_addr_o,
    output logic                        busy_o,
    output logic                        overflow_o
);

    // Payload handshake: the payload transfers on a cycle where pkt_valid_o & pkt_ready_i;
    // while pkt_valid_o is high and pkt_ready_i is low every field holds its value.

    typedef enum logic {IDLE, SEND} state_e;

    state_e                      state_q, state_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]             pend_addr_q, pend_addr_d;
    logic                        overflow_q, overflow_d;
    logic [BRANCH_COUNT_LEN-1:0] branches_q, branches_d;
    logic [BRANCH_MAP_LEN-1:0]   map_q, map_d;
    logic                        has_addr_q, has_addr_d;
    logic [XLEN-1:0]             addr_q, addr_d;

    logic                        req_now;
    logic [XLEN-1:0]             cap_addr;

    assign req_now  = addr_req_i | pend_valid_q;
    assign cap_addr = pend_valid_q ? pend_addr_q : addr_i;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        overflow_d   = overflow_q;
        branches_d   = branches_q;
        map_d        = map_q;
        has_addr_d   = has_addr_q;
        addr_d       = addr_q;
        flush_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_full_i | req_now) begin
                    // A pending request is consumed here; a simultaneous new one takes its place.
                    if (pend_valid_q) begin
                        pend_valid_d = addr_req_i;
                        if (addr_req_i) begin
                            pend_addr_d = addr_i;
                        end
                    end
                    // An empty, non-full map yields no branch packet at all.
                    if (is_full_i || (branches_i != '0)) begin
                        flush_o    = 1'b1;
                        state_d    = SEND;
                        has_addr_d = ~is_full_i | req_now;
                        addr_d     = (~is_full_i | req_now) ? cap_addr : '0;
                        if (is_full_i) begin
                            branches_d = req_now ? BRANCH_COUNT_LEN'(BRANCH_MAP_LEN) : '0;
                        end else begin
                            branches_d = branches_i;
                        end
                        for (int i = 0; i < BRANCH_MAP_LEN; i++) begin
                            map_d[i] = map_i[i] & (is_full_i | (BRANCH_COUNT_LEN'(i) < branches_i));
                        end
                    end
                end
            end
            SEND: begin
                if (addr_req_i) begin
                    if (pend_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = addr_i;
                    end
                end
                // The map cannot be flushed while a packet is outstanding.
                if (is_full_i) begin
                    overflow_d = 1'b1;
                end
                if (pkt_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            overflow_q   <= 1'b0;
            branches_q   <= '0;
            map_q        <= '0;
            has_addr_q   <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            overflow_q   <= overflow_d;
            branches_q   <= branches_d;
            map_q        <= map_d;
            has_addr_q   <= has_addr_d;
            addr_q       <= addr_d;
        end
    end

    assign pkt_valid_o    = (state_q == SEND);
    assign busy_o         = (state_q == SEND);
    assign pkt_format_o   = pkt_valid_o ? 2'b01 : 2'b00;
    assign pkt_branches_o = pkt_valid_o ? branches_q : '0;
    assign pkt_map_o      = pkt_valid_o ? map_q : '0;
    assign pkt_has_addr_o = pkt_valid_o & has_addr_q;
    assign pkt_addr_o     = pkt_valid_o ? addr_q : '0;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_trdb_branch_pkt_emitter.sv
// Bench for trdb_branch_pkt_emitter: directed scenarios plus randomized packets checked
// against a transaction-level model of capture, pending slot and overflow.
module tb_trdb_branch_pkt_emitter;

    localparam int ML = 31;
    localparam int CL = 5;
    localparam int XL = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [ML-1:0] map_i = '0;
    logic [CL-1:0] branches_i = '0;
    logic          is_full_i = 1'b0;
    logic          addr_req_i = 1'b0;
    logic [XL-1:0] addr_i = '0;
    logic          pkt_ready_i = 1'b0;
    logic          flush_o;
    logic          pkt_valid_o;
    logic [1:0]    pkt_format_o;
    logic [CL-1:0] pkt_branches_o;
    logic [ML-1:0] pkt_map_o;
    logic          pkt_has_addr_o;
    logic [XL-1:0] pkt_addr_o;
    logic          busy_o;
    logic          overflow_o;

    int checks = 0;
    int passed = 0;

    // reference model state
    bit            m_pend_v;
    logic [XL-1:0] m_pend_a;
    bit            m_ovf;
    logic [70:0]   exp_q[$];

    trdb_branch_pkt_emitter #(
        .BRANCH_MAP_LEN(ML), .BRANCH_COUNT_LEN(CL), .XLEN(XL)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .map_i(map_i), .branches_i(branches_i),
        .is_full_i(is_full_i), .addr_req_i(addr_req_i), .addr_i(addr_i),
        .pkt_ready_i(pkt_ready_i), .flush_o(flush_o), .pkt_valid_o(pkt_valid_o),
        .pkt_format_o(pkt_format_o), .pkt_branches_o(pkt_branches_o), .pkt_map_o(pkt_map_o),
        .pkt_has_addr_o(pkt_has_addr_o), .pkt_addr_o(pkt_addr_o), .busy_o(busy_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    wire [70:0] pkt_obs = {pkt_format_o, pkt_branches_o, pkt_map_o, pkt_has_addr_o, pkt_addr_o};

    // Expected payload straight from the packet rules.
    function automatic logic [70:0] exp_pkt(bit full, bit req, int br, logic [ML-1:0] mp,
                                            logic [XL-1:0] ad);
        int            cnt;
        int            keep;
        bit            has;
        logic [ML-1:0] m;
        has  = !full || req;
        cnt  = full ? (req ? 31 : 0) : br;
        keep = full ? 31 : br;
        m    = '0;
        for (int i = 0; i < keep; i++) m[i] = mp[i];
        return {2'b01, 5'(cnt), m, has, has ? ad : 32'h0};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        map_i = '0; branches_i = '0; is_full_i = 1'b0;
        addr_req_i = 1'b0; addr_i = '0; pkt_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        m_pend_v = 0; m_pend_a = '0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        checks++;
        if ({flush_o, pkt_valid_o, busy_o, overflow_o, pkt_obs} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {flush_o, pkt_valid_o, busy_o, overflow_o, pkt_obs});
        else passed++;
        do_reset();
    endtask

    task automatic test_full();
        map_i = 31'h0000_0005; branches_i = 5'd31; is_full_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (flush_o !== 1'b1) $display("FAIL full_flush: got %b expected 1", flush_o);
        else passed++;
        step();
        clear_inputs();
        pkt_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, flush_o, pkt_obs} !== {1'b1, 1'b0, 2'b01, 5'd0, 31'h5, 1'b0, 32'h0})
            $display("FAIL full_packet: got %b_%b_%h expected valid=1 flush=0 fmt=1 br=0 map=5",
                     pkt_valid_o, flush_o, pkt_obs);
        else passed++;
        step();
        @(negedge clk_i);
        checks++;
        if (pkt_valid_o !== 1'b0) $display("FAIL full_valid_drop: got %b expected 0", pkt_valid_o);
        else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_addr_req();
        map_i = 31'h7FFF_FFFA; branches_i = 5'd3; addr_req_i = 1'b1; addr_i = 32'h8000_0100;
        @(negedge clk_i);
        checks++;
        if (flush_o !== 1'b1) $display("FAIL addr_flush: got %b expected 1", flush_o);
        else passed++;
        step();
        clear_inputs();
        pkt_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, pkt_obs} !== {1'b1, 2'b01, 5'd3, 31'h2, 1'b1, 32'h8000_0100})
            $display("FAIL addr_packet: got %b_%h expected br=3 map=2 has=1 addr=80000100",
                     pkt_valid_o, pkt_obs);
        else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_stall();
        logic [70:0] exp;
        exp = {2'b01, 5'd6, 31'h2A, 1'b1, 32'h1234_5678};
        map_i = 31'h7FFF_FFEA; branches_i = 5'd6; addr_req_i = 1'b1; addr_i = 32'h1234_5678;
        step();
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            map_i = 31'($urandom); branches_i = 5'($urandom_range(1, 30));
            @(negedge clk_i);
            checks++;
            if ({pkt_valid_o, pkt_obs} !== {1'b1, exp})
                $display("FAIL stall_hold[%0d]: got %b_%h expected 1_%h", c, pkt_valid_o, pkt_obs, exp);
            else passed++;
            step();
        end
        pkt_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (pkt_valid_o !== 1'b1) $display("FAIL stall_valid_at_ready: got %b expected 1", pkt_valid_o);
        else passed++;
        step();
        @(negedge clk_i);
        checks++;
        if (pkt_valid_o !== 1'b0) $display("FAIL stall_valid_drop: got %b expected 0", pkt_valid_o);
        else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_zero_branches();
        branches_i = 5'd0; map_i = 31'h7FFF_FFFF; addr_req_i = 1'b1; addr_i = 32'hDEAD_0000;
        @(negedge clk_i);
        checks++;
        if (flush_o !== 1'b0) $display("FAIL zero_flush: got %b expected 0", flush_o);
        else passed++;
        step();
        clear_inputs();
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, busy_o, overflow_o, flush_o} !== 4'b0)
            $display("FAIL zero_no_packet: got valid/busy/ovf/flush=%b expected 0000",
                     {pkt_valid_o, busy_o, overflow_o, flush_o});
        else passed++;
        step();
    endtask

    task automatic test_pending();
        map_i = 31'h1; branches_i = 5'd2; addr_req_i = 1'b1; addr_i = 32'h50;
        step();
        clear_inputs();
        addr_req_i = 1'b1; addr_i = 32'h100;
        step();
        addr_req_i = 1'b1; addr_i = 32'h200;
        step();
        clear_inputs();
        pkt_ready_i = 1'b1;
        step();
        // back in IDLE: the stored request triggers a capture on its own
        map_i = 31'h7FFF_FFFA; branches_i = 5'd4;
        @(negedge clk_i);
        checks++;
        if ({flush_o, overflow_o} !== 2'b11)
            $display("FAIL pend_flush_ovf: got flush/ovf=%b expected 11", {flush_o, overflow_o});
        else passed++;
        step();
        map_i = '0; branches_i = '0;
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, pkt_obs} !== {1'b1, 2'b01, 5'd4, 31'hA, 1'b1, 32'h100})
            $display("FAIL pend_packet: got %b_%h expected br=4 map=a addr=100", pkt_valid_o, pkt_obs);
        else passed++;
        step();
        branches_i = 5'd3;
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, flush_o} !== 2'b00)
            $display("FAIL pend_dropped_newer: got valid/flush=%b expected 00", {pkt_valid_o, flush_o});
        else passed++;
        step();
        do_reset();
    endtask

    task automatic test_flush_boundary_and_async_reset();
        // branch at the capture cycle is inside the snapshot (bit0 = not taken)
        map_i = 31'h1; branches_i = 5'd1; addr_req_i = 1'b1; addr_i = 32'h300;
        step();
        // the next branch lands in bit 0 of the freshly flushed map
        addr_req_i = 1'b0; map_i = 31'h0; branches_i = 5'd1;
        @(negedge clk_i);
        checks++;
        if ({pkt_valid_o, pkt_obs} !== {1'b1, 2'b01, 5'd1, 31'h1, 1'b1, 32'h300})
            $display("FAIL boundary_snapshot: got %b_%h expected br=1 map=1 addr=300", pkt_valid_o, pkt_obs);
        else passed++;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({pkt_valid_o, busy_o} !== 2'b00)
            $display("FAIL async_reset_valid: got valid/busy=%b expected 00", {pkt_valid_o, busy_o});
        else passed++;
        do_reset();
    endtask

    task automatic test_random();
        bit            full, req, eff_req, drop, rdy, rq, fl;
        int            br;
        logic [ML-1:0] mp;
        logic [XL-1:0] ad, cap_a;
        logic [70:0]   exp;
        for (int it = 0; it < 60; it++) begin
            full = ($urandom_range(0, 3) == 0);
            req  = m_pend_v ? bit'($urandom_range(0, 1)) : (full ? bit'($urandom_range(0, 1)) : 1'b1);
            br   = full ? 31 : (($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30));
            mp   = 31'($urandom);
            ad   = $urandom;
            map_i = mp; branches_i = 5'(br); is_full_i = full; addr_req_i = req; addr_i = ad;
            pkt_ready_i = 1'b0;
            eff_req = m_pend_v | req;
            cap_a   = m_pend_v ? m_pend_a : ad;
            if (m_pend_v) begin
                m_pend_v = req;
                if (req) m_pend_a = ad;
            end
            drop = !full && (br == 0);
            @(negedge clk_i);
            checks++;
            if ({pkt_valid_o, flush_o} !== {1'b0, !drop})
                $display("FAIL rnd_capture[%0d]: got valid/flush=%b expected 0%b", it,
                         {pkt_valid_o, flush_o}, !drop);
            else passed++;
            step();
            clear_inputs();
            if (!drop) begin
                exp_q.push_back(exp_pkt(full, eff_req, br, mp, cap_a));
                exp = exp_q.pop_front();
                for (int c = 0; c < 10; c++) begin
                    rdy = (c >= 6) || ($urandom_range(0, 1) == 1);
                    rq  = ($urandom_range(0, 3) == 0);
                    fl  = ($urandom_range(0, 7) == 0);
                    pkt_ready_i = rdy; addr_req_i = rq; is_full_i = fl;
                    addr_i = $urandom; map_i = 31'($urandom); branches_i = 5'($urandom);
                    @(negedge clk_i);
                    checks++;
                    if ({pkt_valid_o, busy_o, flush_o, overflow_o, pkt_obs} !== {3'b110, m_ovf, exp})
                        $display("FAIL rnd_send[%0d.%0d]: got %b_%h expected %b_%h", it, c,
                                 {pkt_valid_o, busy_o, flush_o, overflow_o}, pkt_obs,
                                 {3'b110, m_ovf}, exp);
                    else passed++;
                    if (rq) begin
                        if (m_pend_v) m_ovf = 1;
                        else begin
                            m_pend_v = 1; m_pend_a = addr_i;
                        end
                    end
                    if (fl) m_ovf = 1;
                    step();
                    if (rdy) break;
                end
                clear_inputs();
            end
        end
        @(negedge clk_i);
        checks++;
        if (overflow_o !== m_ovf) $display("FAIL rnd_overflow: got %b expected %b", overflow_o, m_ovf);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_full();
        test_addr_req();
        test_stall();
        test_zero_branches();
        test_pending();
        test_flush_boundary_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
